// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat round sequencer: state encoding,
// card rank-to-value mapping and the natural / player-draw thresholds.
package baccarat_pkg;

  localparam int CARD_RANK_W     = 4;
  localparam int NATURAL_MIN     = 8;
  localparam int PLAYER_DRAW_MAX = 5;

  typedef enum logic [3:0] {
    DEAL_P1  = 4'd0,
    DEAL_D1  = 4'd1,
    DEAL_P2  = 4'd2,
    DEAL_D2  = 4'd3,
    DECIDE_P = 4'd4,
    DEAL_P3  = 4'd5,
    DECIDE_D = 4'd6,
    DEAL_D3  = 4'd7,
    RESULT   = 4'd8,
    DONE     = 4'd9
  } state_e;

  // Face cards and tens count as zero in baccarat.
  function automatic logic [CARD_RANK_W-1:0] card_value(input logic [CARD_RANK_W-1:0] rank);
    return (rank >= CARD_RANK_W'(10)) ? '0 : rank;
  endfunction

endpackage

// File: rtl/baccarat_dealer_rule.sv
// Baccarat dealer third-card decision: combinational function of the dealer's
// two-card score, whether the player drew a third card, and that card's value.
module baccarat_dealer_rule
  import baccarat_pkg::*;
#(
  parameter int CARD_W = 4
) (
  input  logic [CARD_W-1:0] dscore_i,
  input  logic              p3_drawn_i,
  input  logic [CARD_W-1:0] value_i,
  output logic              draw_o
);

  always_comb begin
    // NOTE: every output of an always_comb gets a default first so that no
    // path through the block leaves it unassigned and infers a latch.
    draw_o = 1'b0;
    if (!p3_drawn_i) begin
      // Without a player third card the dealer follows the same 0..5 draw rule.
      draw_o = (dscore_i <= CARD_W'(PLAYER_DRAW_MAX));
    end else begin
      case (dscore_i)
        CARD_W'(0), CARD_W'(1), CARD_W'(2):
          draw_o = 1'b1;
        CARD_W'(3):
          draw_o = (value_i != CARD_W'(8));
        CARD_W'(4):
          draw_o = (value_i >= CARD_W'(2)) && (value_i <= CARD_W'(7));
        CARD_W'(5):
          draw_o = (value_i >= CARD_W'(4)) && (value_i <= CARD_W'(7));
        CARD_W'(6):
          draw_o = (value_i >= CARD_W'(6)) && (value_i <= CARD_W'(7));
        default:
          draw_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/baccarat_round_sequencer.sv
// Control FSM for one baccarat round: card load strobes, natural/third-card rules and
// winner flags. Define ROUND_STATS_EN to add saturating win/tie statistic counters.
module baccarat_round_sequencer
  import baccarat_pkg::*;
#(
  parameter int CARD_W = 4
`ifdef ROUND_STATS_EN
  ,
  parameter int STAT_W = 8
`endif
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              step,
  input  logic              new_round,
  input  logic [CARD_W-1:0] pscore,
  input  logic [CARD_W-1:0] dscore,
  input  logic [CARD_W-1:0] pcard3,
  output logic [2:0]        load_pcard,
  output logic [2:0]        load_dcard,
  output logic              player_win,
  output logic              dealer_win,
  output logic              round_done,
  output logic [3:0]        state_dbg
`ifdef ROUND_STATS_EN
  ,
  output logic [STAT_W-1:0] p_wins,
  output logic [STAT_W-1:0] d_wins,
  output logic [STAT_W-1:0] ties
`endif
);

  state_e      state_q, state_d;
  logic [2:0]  load_pcard_q, load_pcard_d;
  logic [2:0]  load_dcard_q, load_dcard_d;
  logic        p3_drawn_q, p3_drawn_d;
  logic        player_win_q, player_win_d;
  logic        dealer_win_q, dealer_win_d;

  logic [CARD_W-1:0] p3_value;
  logic              natural;
  logic              dealer_draw;

  assign p3_value = CARD_W'(card_value(CARD_RANK_W'(pcard3)));
  assign natural  = (pscore >= CARD_W'(NATURAL_MIN)) || (dscore >= CARD_W'(NATURAL_MIN));

  baccarat_dealer_rule #(
    .CARD_W (CARD_W)
  ) u_dealer_rule (
    .dscore_i   (dscore),
    .p3_drawn_i (p3_drawn_q),
    .value_i    (p3_value),
    .draw_o     (dealer_draw)
  );

  always_comb begin
    state_d      = state_q;
    load_pcard_d = '0;
    load_dcard_d = '0;
    p3_drawn_d   = p3_drawn_q;
    player_win_d = player_win_q;
    dealer_win_d = dealer_win_q;

    if (new_round) begin
      state_d      = DEAL_P1;
      p3_drawn_d   = 1'b0;
      player_win_d = 1'b0;
      dealer_win_d = 1'b0;
    end else if (step) begin
      unique case (state_q)
        DEAL_P1: begin
          load_pcard_d = 3'b001;
          state_d      = DEAL_D1;
        end
        DEAL_D1: begin
          load_dcard_d = 3'b001;
          state_d      = DEAL_P2;
        end
        DEAL_P2: begin
          load_pcard_d = 3'b010;
          state_d      = DEAL_D2;
        end
        DEAL_D2: begin
          load_dcard_d = 3'b010;
          state_d      = DECIDE_P;
        end
        DECIDE_P: begin
          p3_drawn_d = 1'b0;
          if (natural) begin
            state_d = RESULT;
          end else if (pscore <= CARD_W'(PLAYER_DRAW_MAX)) begin
            p3_drawn_d = 1'b1;
            state_d    = DEAL_P3;
          end else begin
            state_d = DECIDE_D;
          end
        end
        DEAL_P3: begin
          load_pcard_d = 3'b100;
          state_d      = DECIDE_D;
        end
        DECIDE_D: begin
          state_d = dealer_draw ? DEAL_D3 : RESULT;
        end
        DEAL_D3: begin
          load_dcard_d = 3'b100;
          state_d      = RESULT;
        end
        RESULT: begin
          player_win_d = (pscore >= dscore);
          dealer_win_d = (dscore >= pscore);
          state_d      = DONE;
        end
        DONE: begin
          state_d = DONE;
        end
        default: begin
          state_d = DEAL_P1;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      state_q      <= DEAL_P1;
      load_pcard_q <= '0;
      load_dcard_q <= '0;
      p3_drawn_q   <= 1'b0;
      player_win_q <= 1'b0;
      dealer_win_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      load_pcard_q <= load_pcard_d;
      load_dcard_q <= load_dcard_d;
      p3_drawn_q   <= p3_drawn_d;
      player_win_q <= player_win_d;
      dealer_win_q <= dealer_win_d;
    end
  end

  assign load_pcard = load_pcard_q;
  assign load_dcard = load_dcard_q;
  assign player_win = player_win_q;
  assign dealer_win = dealer_win_q;
  assign round_done = (state_q == DONE);
  assign state_dbg  = state_q;

`ifdef ROUND_STATS_EN
  logic              commit;
  logic [STAT_W-1:0] p_wins_q, d_wins_q, ties_q;

  // Counts once per round, on the same edge that registers the winner flags.
  assign commit = step && !new_round && (state_q == RESULT);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      p_wins_q <= '0;
      d_wins_q <= '0;
      ties_q   <= '0;
    end else if (commit) begin
      if (player_win_d && dealer_win_d) begin
        if (ties_q != '1) ties_q <= ties_q + 1'b1;
      end else if (player_win_d) begin
        if (p_wins_q != '1) p_wins_q <= p_wins_q + 1'b1;
      end else begin
        if (d_wins_q != '1) d_wins_q <= d_wins_q + 1'b1;
      end
    end
  end

  assign p_wins = p_wins_q;
  assign d_wins = d_wins_q;
  assign ties   = ties_q;
`endif

endmodule

// File: tb/tb_baccarat_round_sequencer.sv
// Self-checking bench: plays directed and random baccarat rounds, emulating the card
// datapath and comparing strobes/flags (and stats under ROUND_STATS_EN) to a rules model.
module tb_baccarat_round_sequencer;

  logic       CLOCK_50 = 1'b0;
  logic       reset     = 1'b1;
  logic       step      = 1'b0;
  logic       new_round = 1'b0;
  logic [3:0] pscore    = '0;
  logic [3:0] dscore    = '0;
  logic [3:0] pcard3    = '0;
  logic [2:0] load_pcard, load_dcard;
  logic       player_win, dealer_win, round_done;
  logic [3:0] state_dbg;
`ifdef ROUND_STATS_EN
  logic [7:0] p_wins, d_wins, ties;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  // Cards by strobe order: P1, D1, P2, D2, P3, D3.
  int rank [6];
  int psum, dsum;
  int exp_seq [$];
  bit exp_pw, exp_dw;
  int exp_p_wins = 0, exp_d_wins = 0, exp_ties = 0;

  // Dealer draw set per dealer score 0..7, bit v set when the dealer draws on player card value v.
  int dealer_mask [8] = '{1023, 1023, 1023, 767, 252, 240, 192, 0};

  always #10 CLOCK_50 = ~CLOCK_50;

  baccarat_round_sequencer dut (
    .CLOCK_50   (CLOCK_50),
    .reset      (reset),
    .step       (step),
    .new_round  (new_round),
    .pscore     (pscore),
    .dscore     (dscore),
    .pcard3     (pcard3),
    .load_pcard (load_pcard),
    .load_dcard (load_dcard),
    .player_win (player_win),
    .dealer_win (dealer_win),
    .round_done (round_done),
    .state_dbg  (state_dbg)
`ifdef ROUND_STATS_EN
    ,
    .p_wins     (p_wins),
    .d_wins     (d_wins),
    .ties       (ties)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cv(input int r);
    return (r >= 10) ? 0 : r;
  endfunction

  function automatic int strobe_code();
    case ({load_pcard, load_dcard})
      6'b000000: return -1;
      6'b001000: return 0;
      6'b000001: return 1;
      6'b010000: return 2;
      6'b000010: return 3;
      6'b100000: return 4;
      6'b000100: return 5;
      default:   return 9;
    endcase
  endfunction

  task automatic cycle();
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
  endtask

  task automatic model_round();
    int p, d, v3;
    bit p3, d3;
    exp_seq = {0, 1, 2, 3};
    p = (cv(rank[0]) + cv(rank[2])) % 10;
    d = (cv(rank[1]) + cv(rank[3])) % 10;
    if (p < 8 && d < 8) begin
      p3 = (p <= 5);
      v3 = cv(rank[4]);
      if (p3) begin
        exp_seq.push_back(4);
        p = (p + v3) % 10;
      end
      d3 = p3 ? (((dealer_mask[d] >> v3) & 1) != 0) : (d <= 5);
      if (d3) begin
        exp_seq.push_back(5);
        d = (d + cv(rank[5])) % 10;
      end
    end
    exp_pw = (p >= d);
    exp_dw = (d >= p);
  endtask

  task automatic check_stats(input string tag);
`ifdef ROUND_STATS_EN
    check({tag, " p_wins"}, p_wins, exp_p_wins);
    check({tag, " d_wins"}, d_wins, exp_d_wins);
    check({tag, " ties"}, ties, exp_ties);
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  task automatic start_round();
    new_round = 1'b1;
    cycle();
    new_round = 1'b0;
    psum = 0;
    dsum = 0;
    pscore = '0;
    dscore = '0;
  endtask

  // One step pulse, then one idle cycle; the strobe may appear only in the first.
  task automatic do_step(input string tag, output int code);
    step = 1'b1;
    cycle();
    step = 1'b0;
    code = strobe_code();
    check({tag, " onehot"}, $countones({load_pcard, load_dcard}) <= 1, 1);
    if (code >= 0 && code <= 5) begin
      if (code % 2 == 0) psum += cv(rank[code]);
      else dsum += cv(rank[code]);
      pscore = 4'(psum % 10);
      dscore = 4'(dsum % 10);
    end
    cycle();
    check({tag, " gap"}, {26'd0, load_pcard, load_dcard}, 0);
  endtask

  task automatic run_round(input string tag);
    int obs [$];
    int code;
    int steps;
    model_round();
    pcard3 = 4'(rank[4]);
    start_round();
    check({tag, " start state"}, state_dbg, 0);
    steps = 0;
    while (!round_done && steps < 12) begin
      do_step(tag, code);
      if (code >= 0) obs.push_back(code);
      steps++;
    end
    check({tag, " done"}, round_done, 1);
    check({tag, " strobe count"}, obs.size(), exp_seq.size());
    for (int i = 0; i < exp_seq.size() && i < obs.size(); i++)
      check({tag, " strobe order"}, obs[i], exp_seq[i]);
    check({tag, " player_win"}, player_win, exp_pw);
    check({tag, " dealer_win"}, dealer_win, exp_dw);
    if (exp_pw && exp_dw) exp_ties++;
    else if (exp_pw) exp_p_wins++;
    else exp_d_wins++;
    check_stats(tag);
    // DONE ignores further steps.
    for (int i = 0; i < 2; i++) begin
      do_step({tag, " done hold"}, code);
      check({tag, " done hold strobe"}, code, -1);
    end
    check({tag, " hold done"}, round_done, 1);
    check({tag, " hold pw"}, player_win, exp_pw);
    check({tag, " hold dw"}, dealer_win, exp_dw);
    check_stats({tag, " hold"});
  endtask

  initial begin
    int code;

    // Reset with a step pending: nothing may move.
    reset = 1'b1;
    step  = 1'b1;
    cycle();
    cycle();
    step = 1'b0;
    check("reset state", state_dbg, 0);
    check("reset strobes", {26'd0, load_pcard, load_dcard}, 0);
    check("reset flags", {player_win, dealer_win, round_done}, 0);
    check_stats("reset");
    reset = 1'b0;
    cycle();

    // Natural: player 8 vs dealer 3.
    rank = '{3, 1, 5, 2, 9, 9};
    run_round("natural");
    // Player draws a face card, dealer on 3 draws: 5 vs 5 tie.
    rank = '{2, 1, 3, 2, 12, 2};
    run_round("tie p3 d3");
    // Player 7 stands, dealer 6 stands.
    rank = '{3, 2, 4, 4, 1, 1};
    run_round("both stand");
    // Player draws an 8, dealer on 3 stands.
    rank = '{1, 1, 2, 2, 8, 5};
    run_round("dealer 3 vs 8");

    // new_round together with step from DONE: clears flags, no strobe.
    new_round = 1'b1;
    step      = 1'b1;
    cycle();
    new_round = 1'b0;
    step      = 1'b0;
    check("nr done state", state_dbg, 0);
    check("nr done strobes", {26'd0, load_pcard, load_dcard}, 0);
    check("nr done flags", {player_win, dealer_win, round_done}, 0);
    check_stats("nr done");

    // new_round together with step mid-deal.
    rank = '{5, 5, 5, 5, 5, 5};
    start_round();
    do_step("mid", code);
    check("mid p1 strobe", code, 0);
    new_round = 1'b1;
    step      = 1'b1;
    cycle();
    new_round = 1'b0;
    step      = 1'b0;
    check("nr mid state", state_dbg, 0);
    check("nr mid strobes", {26'd0, load_pcard, load_dcard}, 0);

    // Reset together with step mid-deal: aborts, clears stats.
    start_round();
    do_step("abort", code);
    reset = 1'b1;
    step  = 1'b1;
    cycle();
    reset = 1'b0;
    step  = 1'b0;
    exp_p_wins = 0;
    exp_d_wins = 0;
    exp_ties   = 0;
    check("abort state", state_dbg, 0);
    check("abort strobes", {26'd0, load_pcard, load_dcard}, 0);
    check_stats("abort");

    for (int i = 0; i < 40; i++) begin
      for (int k = 0; k < 6; k++) rank[k] = int'($urandom_range(13, 1));
      run_round("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
